// File: rtl/edge_case_stim_tx.sv
// Stimulus transmitter and loopback checker: sends counter/LFSR bursts on paired
// reg_/wire_ lanes and counts mismatches against a LAT-deep copy of the traffic.
module edge_case_stim_tx #(
  parameter int LAT   = 1,
  parameter int LEN_W = 5,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic [7:0]       seed,
  input  logic             mode,
  output logic [7:0]       reg_data,
  output logic             reg_enable,
  output logic [7:0]       wire_data,
  output logic             wire_enable,
  input  logic             reg_valid,
  input  logic [7:0]       output_reg,
  output logic             busy,
  output logic             done,
  output logic [7:0]       mismatch_count,
  output logic             err_flag
);

  localparam logic [2:0] LAT_C = 3'(LAT);

  typedef enum logic [2:0] {IDLE, SEND, GAP, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic             mode_q, mode_d;
  logic [7:0]       gen_q, gen_d;
  logic [7:0]       last_q, last_d;
  logic [7:0]       mis_q, mis_d;
  logic [LAT-1:0][8:0] dly_q;

  logic       accept;
  logic       mismatch;
  logic [8:0] exp_q;

  function automatic logic [7:0] gen_next(input logic [7:0] x, input logic m);
    return m ? ((x >> 1) ^ (x[0] ? 8'hB8 : 8'h00)) : x + 8'd1;
  endfunction

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    // NOTE: every always_comb target gets its default first so no path can infer a latch.
    state_d     = state_q;
    rem_d       = rem_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mode_d      = mode_q;
    gen_d       = gen_q;
    last_d      = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = burst_len;
          gap_len_d = gap_cycles;
          mode_d    = mode;
          gen_d     = (mode && seed == 8'h00) ? 8'h01 : seed;
          if (burst_len == '0) begin
            state_d     = DRAIN;
            drain_cnt_d = LAT_C;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        gen_d  = gen_next(gen_q, mode_q);
        last_d = gen_q;
        rem_d  = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d     = DRAIN;
          drain_cnt_d = LAT_C;
        end else if (gap_len_q != '0) begin
          state_d   = GAP;
          gap_cnt_d = gap_len_q;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(1)) state_d = SEND;
        else                        gap_cnt_d = gap_cnt_q - 1'b1;
      end
      DRAIN: begin
        if (drain_cnt_q == 3'd1) state_d = DONE;
        else                     drain_cnt_d = drain_cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Checker compares the returned pair with the enable/data sent LAT cycles ago.
  assign exp_q    = dly_q[LAT-1];
  assign mismatch = exp_q[8] ? (!reg_valid || output_reg != exp_q[7:0]) : reg_valid;

  always_comb begin
    mis_d = mis_q;
    if (accept)                         mis_d = 8'h00;
    else if (mismatch && mis_q != 8'hFF) mis_d = mis_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      mode_q      <= 1'b0;
      gen_q       <= 8'h00;
      last_q      <= 8'h00;
      mis_q       <= 8'h00;
      // NOTE: the delay line is reset so stale traffic cannot raise mismatches after an abort.
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mode_q      <= mode_d;
      gen_q       <= gen_d;
      last_q      <= last_d;
      mis_q       <= mis_d;
      dly_q[0]    <= {reg_enable, reg_data};
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign reg_enable     = (state_q == SEND);
  assign reg_data       = reg_enable ? gen_q : last_q;
  assign wire_enable    = reg_enable;
  assign wire_data      = ~reg_data;
  assign busy           = (state_q == SEND) || (state_q == GAP) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign mismatch_count = mis_q;
  assign err_flag       = (mis_q != 8'h00);

endmodule
